// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the SubBytes datapath.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_NBYTES  = 16;

  typedef logic [AES_STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {SB_IDLE, SB_RUN, SB_DONE} sb_state_e;

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] aes_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = aes_xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as SubBytes requires.
  function automatic logic [7:0] aes_gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = aes_gf_mul(aes_gf_mul(r, r), a);  // a^(2^(i+2)-1)
    end
    return aes_gf_mul(r, r);
  endfunction

  function automatic logic [7:0] aes_rotl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] aes_sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = aes_gf_inv(a);
    return b ^ aes_rotl8(b, 1) ^ aes_rotl8(b, 2) ^ aes_rotl8(b, 3) ^ aes_rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_sbox_inv(input logic [7:0] s);
    logic [7:0] b;
    b = aes_rotl8(s, 1) ^ aes_rotl8(s, 3) ^ aes_rotl8(s, 6) ^ 8'h05;
    return aes_gf_inv(b);
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One SubBytes lane: forward S-box, plus an inverse S-box when INV_EN is set.
module aes_sbox_lane #(
  parameter bit INV_EN = 1'b1
) (
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  logic [7:0] fwd_byte;

  sbox u_sbox (
    .data_i (data_i),
    .data_o (fwd_byte)
  );

  if (INV_EN) begin : gen_inv
    logic [7:0] inv_byte;

    inv_sbox u_inv_sbox (
      .data_i (data_i),
      .data_o (inv_byte)
    );

    assign data_o = inv_i ? inv_byte : fwd_byte;
  end else begin : gen_fwd_only
    logic unused_inv;
    assign unused_inv = inv_i;
    assign data_o     = fwd_byte;
  end

endmodule

// File: rtl/inv_sbox.sv
// Inverse AES S-box, purely combinational.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  assign data_o = aes_sbox_inv(data_i);

endmodule

// File: rtl/sbox.sv
// Forward AES S-box, purely combinational.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  assign data_o = aes_sbox_fwd(data_i);

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential SubBytes: NUM_SBOX lanes substitute the 16-byte state in BEATS passes.
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 4,
  parameter bit          INV_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  input  logic       in_inv,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state,
  output logic       busy
);

  localparam int unsigned BEATS  = AES_NBYTES / NUM_SBOX;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LANE_W = 8 * NUM_SBOX;
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16))
  begin : gen_bad_num_sbox
    $error("aes_sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  sb_state_e        state_q;
  aes_state_t       work_q;
  logic             inv_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [LANE_W-1:0] lane_in;
  logic [LANE_W-1:0] lane_out;
  aes_state_t        work_upd;
  logic              in_accept;

  assign in_ready  = (state_q == SB_IDLE) || ((state_q == SB_DONE) && out_ready);
  assign in_accept = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

  // Select the current beat's bytes and splice the substituted bytes back in place.
  if (BEATS == 1) begin : gen_single_beat
    assign lane_in  = work_q;
    assign work_upd = lane_out;
  end else begin : gen_multi_beat
    assign lane_in = work_q[cnt_q*LANE_W +: LANE_W];

    always_comb begin
      work_upd = work_q;
      work_upd[cnt_q*LANE_W +: LANE_W] = lane_out;
    end
  end

  for (genvar g = 0; g < NUM_SBOX; g++) begin : gen_lane
    aes_sbox_lane #(
      .INV_EN (INV_EN)
    ) u_lane (
      .data_i (lane_in[8*g +: 8]),
      .inv_i  (inv_q),
      .data_o (lane_out[8*g +: 8])
    );
  end

  // Control FSM with registered out_valid/busy; also owns the work register and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SB_IDLE;
      work_q      <= '0;
      inv_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        SB_IDLE: begin
          if (in_accept) begin
            state_q <= SB_RUN;
            work_q  <= in_state;
            inv_q   <= INV_EN && in_inv;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SB_RUN: begin
          work_q <= work_upd;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            state_q     <= SB_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        SB_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_accept) begin
              // Back-to-back: reload without passing through IDLE.
              state_q <= SB_RUN;
              work_q  <= in_state;
              inv_q   <= INV_EN && in_inv;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= SB_IDLE;
            end
          end
        end
        default: begin
          state_q     <= SB_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
